// File: rtl/dmem_ctrl_if.sv
// Datapath-to-memory bus bundle for dmem_ctrl.
// slave  : the controller's view (requests and memory responses come in).
// master : the environment's view (datapath plus memory model).
interface dmem_ctrl_if;
    // datapath side
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    // memory side
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, addr, wdata,
        input  mem_rdata, mem_ready,
        output rdata, stall, err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, addr, wdata,
        output mem_rdata, mem_ready,
        input  rdata, stall, err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: aligns loads/stores onto a 32-bit word
// memory, extends load data, stalls the datapath while the access is in
// flight and aborts with an error if the memory never answers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; illegal requests raise err here
// S_ACCESS | memory strobe held, waiting for mem_ready or timeout
// S_DONE   | one unstalled cycle so the datapath retires the instruction
//
// err is a registered pulse: it shows the cycle after an illegal request
// is presented, and during S_DONE after a timeout.
module dmem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    dmem_ctrl_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_legal;
    logic        w_req_ok;
    logic        w_req_bad;
    logic        w_in_access;
    logic        w_timeout;
    logic        w_stall;
    logic        w_mem_en;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_lane;
    logic [31:0] w_load_ext;

    // Alignment check on the incoming request.
    always_comb begin
        w_legal = 1'b0;
        case (bus.req_size)
            2'b00:   w_legal = 1'b1;
            2'b01:   w_legal = ~bus.addr[0];
            2'b10:   w_legal = (bus.addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_in_access = (r_state == S_ACCESS);
    assign w_req_ok    = (r_state == S_IDLE) & bus.req_valid & w_legal;
    assign w_req_bad   = (r_state == S_IDLE) & bus.req_valid & ~w_legal;
    // mem_ready on the last allowed cycle still completes the access.
    assign w_timeout   = w_in_access & ~bus.mem_ready & (r_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_mem_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_stall  = 1'b1;
                w_mem_en = 1'b1;
                if (bus.mem_ready || w_timeout) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request so the memory-side outputs stay stable during ACCESS.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else if (w_req_ok) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.addr;
            r_wdata  <= bus.wdata;
        end
    end

    // Wait counter: cleared on ACCESS entry, counts cycles without mem_ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                           r_cnt <= '0;
        else if (w_req_ok)                   r_cnt <= '0;
        else if (w_in_access && !bus.mem_ready) r_cnt <= r_cnt + CW'(1);
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << r_addr[1:0];
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // Select the addressed lane and extend it.
    always_comb begin
        w_lane     = bus.mem_rdata >> {r_addr[1:0], 3'b000};
        w_load_ext = w_lane;
        case (r_size)
            2'b00:   w_load_ext = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
            default: w_load_ext = w_lane;
        endcase
    end

    // Load result register; a timeout forces zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                    r_rdata <= 32'h0;
        else if (w_in_access && bus.mem_ready && !r_we) r_rdata <= w_load_ext;
        else if (w_timeout)                           r_rdata <= 32'h0;
    end

    // Error pulse for illegal requests and timeouts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_err <= 1'b0;
        else       r_err <= w_req_bad | w_timeout;
    end

    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.stall     = w_stall;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_in_access & r_we;
    assign bus.mem_be    = w_in_access ? w_be : 4'b0000;
    assign bus.mem_addr  = r_addr[31:2];
    assign bus.mem_wdata = w_wdata_rep;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases followed by random transactions,
// each checked against a transaction-level model of the access rules.
module tb_dmem_ctrl;

    localparam int TO = 15;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_rdata;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One full transaction; lat = ACCESS cycle index carrying mem_ready,
    // lat >= TO means the memory never answers.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic sgn, input logic [31:0] wd, input logic [31:0] rword,
                          input int lat);
        int          n;
        int          off;
        int          n_acc;
        bit          legal;
        bit          tmo;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] mask;
        logic [31:0] v;
        logic [31:0] old_rdata;

        n     = 1 << size;
        off   = int'(addr[1:0]);
        legal = (size != 2'b11) && ((off % n) == 0);
        ebe   = 4'b0000;
        ewd   = 32'h0;
        if (legal) begin
            for (int i = 0; i < n; i++) ebe[off + i] = 1'b1;
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        tmo   = (lat >= TO);
        n_acc = tmo ? TO : lat + 1;
        old_rdata = exp_rdata;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.addr       = addr;
        bus.wdata      = wd;
        bus.mem_ready  = 1'b0;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'(legal));
        chk("idle_mem_en", 32'(bus.mem_en), 32'h0);
        chk("idle_err", 32'(bus.err), 32'h0);

        if (!legal) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("bad_err", 32'(bus.err), 32'h1);
            chk("bad_mem_en", 32'(bus.mem_en), 32'h0);
            chk("bad_stall", 32'(bus.stall), 32'h0);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            chk("bad_err_drop", 32'(bus.err), 32'h0);
            chk("bad_rdata", bus.rdata, exp_rdata);
            return;
        end

        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.addr      = $urandom;
            bus.wdata     = $urandom;
            bus.mem_ready = (k == lat);
            bus.mem_rdata = (k == lat) ? rword : $urandom;
            #1;
            chk("acc_mem_en", 32'(bus.mem_en), 32'h1);
            chk("acc_stall", 32'(bus.stall), 32'h1);
            chk("acc_mem_we", 32'(bus.mem_we), 32'(we));
            chk("acc_mem_be", 32'(bus.mem_be), 32'(ebe));
            chk("acc_mem_addr", 32'(bus.mem_addr), addr >> 2);
            chk("acc_mem_wdata", bus.mem_wdata, ewd);
            chk("acc_rdata", bus.rdata, old_rdata);
        end

        if (tmo) begin
            exp_rdata = 32'h0;
        end else if (!we) begin
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            v    = (rword >> (8 * off)) & mask;
            if (sgn && n < 4 && v[8*n - 1]) v = v | ~mask;
            exp_rdata = v;
        end

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("done_mem_en", 32'(bus.mem_en), 32'h0);
        chk("done_stall", 32'(bus.stall), 32'h0);
        chk("done_err", 32'(bus.err), 32'(tmo));
        chk("done_rdata", bus.rdata, exp_rdata);

        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("post_mem_en", 32'(bus.mem_en), 32'h0);
        chk("post_stall", 32'(bus.stall), 32'h0);
        chk("post_err", 32'(bus.err), 32'h0);
        chk("post_rdata", bus.rdata, exp_rdata);
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sz;
        logic [31:0] a;
        int lat;
        int r;

        n_tests = 0;
        n_fail  = 0;
        exp_rdata = 32'h0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        #2;
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        do_txn(1'b0, 2'b10, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        do_txn(1'b0, 2'b00, 32'h103, 1'b1, 32'h0, 32'h80FF1234, 0);
        do_txn(1'b0, 2'b00, 32'h103, 1'b0, 32'h0, 32'h80FF1234, 0);
        do_txn(1'b1, 2'b01, 32'h202, 1'b0, 32'h0000ABCD, 32'h0, 0);
        do_txn(1'b0, 2'b10, 32'h102, 1'b0, 32'h0, 32'h0, 0);
        do_txn(1'b0, 2'b10, 32'h104, 1'b0, 32'h0, 32'h12345678, TO - 1);
        do_txn(1'b0, 2'b10, 32'h108, 1'b0, 32'h0, 32'h0, TO);

        // load something, then reset during the 2nd ACCESS cycle of the next load
        do_txn(1'b0, 2'b10, 32'h100, 1'b0, 32'h0, 32'hCAFEF00D, 1);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.addr      = 32'h100;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pre_mem_en", 32'(bus.mem_en), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mid_stall", 32'(bus.stall), 32'h0);
        chk("rst_mid_rdata", bus.rdata, 32'h0);
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555AAAA;
        #1;
        chk("late_ready_mem_en", 32'(bus.mem_en), 32'h0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("late_ready_rdata", bus.rdata, 32'h0);
        chk("late_ready_stall", 32'(bus.stall), 32'h0);
        chk("late_ready_err", 32'(bus.err), 32'h0);

        // random transactions
        for (int t = 0; t < 80; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            r = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 3);
            else if (r == 6) lat = TO - 1;
            else if (r == 7) lat = TO;
            else             lat = $urandom_range(4, 10);
            do_txn(1'($urandom_range(0, 1)), sz, a, 1'($urandom_range(0, 1)),
                   $urandom, $urandom, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
